// File: rtl/pwm_current_ctrl.sv
// Hysteretic current-mode PWM controller with min/max dwell limits.
// Optional overcurrent trip latch and FAULT state under `PWM_OCP_EN`.
module pwm_current_ctrl #(
  parameter int HYST    = 20,
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 8,
  parameter int MAX_ON  = 4000,
  parameter int I_TRIP  = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] i_target,
  input  logic [11:0] iest_coil,
  input  logic        fault_clr,
  output logic        pwm,
  output logic [1:0]  state,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFF   = 2'd1,
    ON    = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [15:0] MIN_ON_M1  = 16'(MIN_ON - 1);
  localparam logic [15:0] MIN_OFF_M1 = 16'(MIN_OFF - 1);
  localparam logic [15:0] MAX_ON_M1  = 16'(MAX_ON - 1);
  localparam logic signed [12:0] HYST_S = 13'(HYST);

  state_t      state_q, state_d;
  logic [15:0] dwell_q, dwell_d;
  logic        pwm_q, pwm_d;

  logic signed [11:0] i_meas;
  logic signed [12:0] i_meas_x, tgt_x, upper, lower;

  // Offset-binary code to signed: flip every bit except the MSB.
  assign i_meas   = signed'(iest_coil ^ 12'h7FF);
  assign i_meas_x = {i_meas[11], i_meas};
  assign tgt_x    = {i_target[11], i_target};
  assign upper    = tgt_x + HYST_S;
  assign lower    = tgt_x - HYST_S;

`ifdef PWM_OCP_EN
  localparam logic [12:0] I_TRIP_U = 13'(I_TRIP);
  logic [12:0] i_mag;
  logic        trip;
  logic        fault_q, fault_d;

  assign i_mag = i_meas_x[12] ? 13'(-i_meas_x) : 13'(i_meas_x);
  assign trip  = i_mag > I_TRIP_U;
`else
  logic unused_ok;
  assign unused_ok = fault_clr;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = OFF;
      end
      OFF: begin
        if (!enable)
          state_d = IDLE;
        else if (dwell_q >= MIN_OFF_M1 && i_meas_x < lower)
          state_d = ON;
      end
      ON: begin
        if (!enable)
          state_d = IDLE;
        else if (dwell_q == MAX_ON_M1)
          state_d = OFF;
        else if (dwell_q >= MIN_ON_M1 && i_meas_x >= upper)
          state_d = OFF;
      end
      default: begin
`ifdef PWM_OCP_EN
        if (fault_clr && !enable) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
    endcase
`ifdef PWM_OCP_EN
    // Trip overrides every other exit, including max-on and enable drop.
    if (state_q != FAULT && trip) state_d = FAULT;
`endif
  end

  always_comb begin
    if (state_d != state_q)
      dwell_d = '0;
    else if (dwell_q == '1)
      dwell_d = dwell_q;
    else
      dwell_d = dwell_q + 16'd1;
    pwm_d = (state_d == ON);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dwell_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      pwm_q   <= pwm_d;
    end
  end

`ifdef PWM_OCP_EN
  assign fault_d = (state_d == FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign pwm   = pwm_q;
  assign state = state_q;

endmodule

// File: tb/tb_pwm_current_ctrl.sv
// Directed, table-driven bench for pwm_current_ctrl (MAX_ON overridden to 100).
module tb_pwm_current_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] i_target;
  logic [11:0] iest_coil;
  logic        fault_clr;
  logic        pwm;
  logic [1:0]  state;
  logic        fault;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pwm_current_ctrl #(
    .HYST(20), .MIN_ON(8), .MIN_OFF(8), .MAX_ON(100), .I_TRIP(2000)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .i_target(i_target),
    .iest_coil(iest_coil), .fault_clr(fault_clr),
    .pwm(pwm), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic [11:0] iest;
    int unsigned n;
    logic [1:0]  st;
    logic        pw;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pwm(input logic lvl, input int unsigned bound, output int unsigned cnt);
    cnt = 0;
    while (pwm != lvl && cnt < bound) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    int unsigned cnt;
    int unsigned hi, lo;

    vecs[0]  = '{"idle_hold",      1'b0, 12'h7FF, 1, 2'd0, 1'b0};
    vecs[1]  = '{"startup_off",    1'b1, 12'h7FF, 1, 2'd1, 1'b0};
    vecs[2]  = '{"min_off_hold",   1'b1, 12'h7FF, 7, 2'd1, 1'b0};
    vecs[3]  = '{"first_on",       1'b1, 12'h7FF, 1, 2'd2, 1'b1};
    vecs[4]  = '{"min_on_hold",    1'b1, 12'd1617, 7, 2'd2, 1'b1};
    vecs[5]  = '{"on_429_keeps",   1'b1, 12'd1618, 3, 2'd2, 1'b1};
    vecs[6]  = '{"on_430_off",     1'b1, 12'd1617, 1, 2'd1, 1'b0};
    vecs[7]  = '{"off_min_hold",   1'b1, 12'd1658, 7, 2'd1, 1'b0};
    vecs[8]  = '{"off_390_keeps",  1'b1, 12'd1657, 3, 2'd1, 1'b0};
    vecs[9]  = '{"off_389_on",     1'b1, 12'd1658, 1, 2'd2, 1'b1};
    vecs[10] = '{"on_dwell2",      1'b1, 12'h7FF, 2, 2'd2, 1'b1};
    vecs[11] = '{"enable_drop",    1'b0, 12'h7FF, 1, 2'd0, 1'b0};

    reset = 1'b1; enable = 1'b0; i_target = 12'd410;
    iest_coil = 12'h7FF; fault_clr = 1'b0;
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_fault", int'(fault), 0);
    tick(2);
    reset = 1'b0;

    foreach (vecs[i]) begin
      enable = vecs[i].en;
      iest_coil = vecs[i].iest;
      tick(vecs[i].n);
      chk({vecs[i].name, "_state"}, int'(state), int'(vecs[i].st));
      chk({vecs[i].name, "_pwm"}, int'(pwm), int'(vecs[i].pw));
      chk({vecs[i].name, "_fault"}, int'(fault), 0);
    end

    // Max-on: constant 0 A below the band gives 100 high / 8 low, repeating.
    enable = 1'b1; iest_coil = 12'h7FF;
    wait_pwm(1'b1, 50, cnt);
    chk("maxon_first_rise_timeout", int'(pwm), 1);
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      while (pwm == 1'b1 && hi < 200) begin hi++; tick(1); end
      chk("maxon_high_len", int'(hi), 100);
      lo = 0;
      while (pwm == 1'b0 && lo < 200) begin lo++; tick(1); end
      chk("maxon_low_len", int'(lo), 8);
    end

    // Async reset mid-pulse drops pwm before the next edge.
    #2;
    chk("pre_reset_pwm", int'(pwm), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_pwm", int'(pwm), 0);
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_fault", int'(fault), 0);
    enable = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("post_reset_idle", int'(state), 0);
    enable = 1'b1;
    tick(1);
    chk("restart_off", int'(state), 1);
    tick(7);
    chk("restart_min_off", int'(pwm), 0);
    tick(1);
    chk("restart_on", int'(pwm), 1);

`ifdef PWM_OCP_EN
    iest_coil = 12'd47;
    tick(1);
    chk("no_trip_2000", int'(state), 2);
    iest_coil = 12'd46;
    tick(1);
    chk("trip_state", int'(state), 3);
    chk("trip_fault", int'(fault), 1);
    chk("trip_pwm", int'(pwm), 0);
    iest_coil = 12'h7FF; fault_clr = 1'b1;
    tick(2);
    chk("clr_with_enable", int'(state), 3);
    enable = 1'b0;
    tick(1);
    chk("clr_state", int'(state), 0);
    chk("clr_fault", int'(fault), 0);
    fault_clr = 1'b0; enable = 1'b1;
    tick(1);
    chk("neg_pre_off", int'(state), 1);
    iest_coil = 12'hFFF;
    tick(1);
    chk("trip_neg2048", int'(state), 3);
    chk("trip_neg2048_fault", int'(fault), 1);
`else
    fault_clr = 1'b1;
    iest_coil = 12'h7FF;
    tick(2);
    chk("noocp_fault", int'(fault), 0);
    chk("noocp_fault_clr_ignored", int'(state), 2);
    iest_coil = 12'd46;
    tick(1);
    chk("noocp_no_trip", int'(state), 2);
    fault_clr = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_current_ctrl.md
# pwm_current_ctrl

Hysteretic current-mode PWM controller that closes the loop around the coil current model. It consumes the model's estimated coil current (ADC offset format) and produces the `pwm` gate drive that the model and power stage consume. Switching is governed by a signed current setpoint with a hysteresis band, minimum on/off dwell, a maximum on-time limit, and an optional overcurrent trip latch.

## Interface
- `HYST`, 20: half-width of hysteresis band, DN (205 DN/A)
- `MIN_ON`, 8: minimum cycles `pwm` stays high per pulse (≥1)
- `MIN_OFF`, 8: minimum cycles `pwm` stays low between pulses (≥1)
- `MAX_ON`, 4000: maximum cycles `pwm` stays high per pulse (≥ `MIN_ON`, ≤ 65535)
- `I_TRIP`, 2000: overcurrent magnitude threshold, DN (`PWM_OCP_EN` only)

- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `enable` in 1: run request
- `i_target` in 12: signed two's-complement current setpoint, 205 DN/A
- `iest_coil` in 12: estimated coil current, ADC offset format (+-10A = -+2050 + 2048)
- `fault_clr` in 1: fault clear request
- `pwm` out 1: registered gate drive, 1 = switch on
- `state` out 2: 0 IDLE, 1 OFF, 2 ON, 3 FAULT
- `fault` out 1: overcurrent latch, high while in FAULT

## Operation
- Measurement: `i_meas` = signed(`iest_coil` ^ 12'h7FF).
- Band: `upper` = `i_target` + `HYST`, `lower` = `i_target` − `HYST`. Compute in 13-bit signed (sign-extend); no saturation, no overflow.
- `dwell`: 16-bit counter. It is 0 on the first cycle in a state and increments each cycle, saturating at 0xFFFF.
- `pwm` = registered (next state == ON). `fault` = registered (next state == FAULT).
- Transitions, highest priority first:
  - Any state except FAULT, with `|i_meas|` > `I_TRIP` → FAULT (`PWM_OCP_EN` only). Use 13-bit magnitude; −2048 trips.
  - IDLE: `enable` → OFF.
  - OFF:
    - `!enable` → IDLE.
    - Else `dwell` ≥ `MIN_OFF`−1 and `i_meas` < `lower` → ON.
  - ON:
    - `!enable` → IDLE immediately, overriding `MIN_ON`.
    - `dwell` = `MAX_ON`−1 → OFF, regardless of current.
    - `dwell` ≥ `MIN_ON`−1 and `i_meas` ≥ `upper` → OFF.
  - FAULT: `fault_clr` and `!enable` → IDLE. `fault_clr` with `enable` high is ignored.
- Equal-to-boundary behaviour: `i_meas` == `lower` does not turn on; `i_meas` == `upper` turns off.
- A max-on exit enters OFF normally, so `MIN_OFF` is enforced after it.
- `i_target` may change at any time and takes effect on the next compare; there is no reset of `dwell`.

## Timing
- Reset (async): `state`=IDLE, `pwm`=0, `fault`=0, `dwell`=0. `pwm` drops within the reset assertion, not at the next edge.
- Latency:
  - Inputs sampled at edge k drive `state`/`pwm`/`fault` after edge k (one cycle).
  - Total loop latency with the coil model (one-cycle accumulator plus one-cycle scale register) is 3 cycles. The compare has no extra pipeline.
- Pulse widths: `pwm` high for at least `MIN_ON` cycles and at most `MAX_ON` cycles, unless `enable` drops or a trip occurs. `pwm` low for at least `MIN_OFF` cycles between pulses.
- From IDLE with `enable` high at edge 0: OFF after edge 0. The earliest ON is after edge `MIN_OFF`.
- Reset mid-pulse: returns to IDLE. `enable` must be re-sampled, and the full `MIN_OFF` applies again.
- Simultaneous trip and max-on, or trip and `!enable`: FAULT wins.

## Configuration
- `PWM_OCP_EN` defined: trip compare, FAULT state, and latch are implemented as above.
- `PWM_OCP_EN` undefined:
  - No trip logic; FAULT is unreachable.
  - `fault` is tied 0 and `fault_clr` is ignored.
  - `I_TRIP` is unused.
  - `state` never reads 3.

## Test plan
- Reset: reach ON, assert `reset` between edges → `pwm`=0 before the next edge, `state`=0, `fault`=0. After release, stays IDLE while `enable`=0.
- Start-up: `enable`=1, `i_target`=410, `iest_coil`=0x7FF (0 A) → `state`=1 after edge 0, `pwm`=1 after edge 8 (`MIN_OFF`=8).
- Hysteresis at `i_target`=410, `HYST`=20:
  - In ON past `MIN_ON`: `iest_coil`=1618 (429) keeps ON; 1617 (430) → OFF next edge.
  - In OFF past `MIN_OFF`: 1657 (390) keeps OFF; 1658 (389) → ON next edge.
- Max on: `MAX_ON`=100, `iest_coil` held at 0x7FF → `pwm` high exactly 100 cycles, low exactly 8 cycles, repeating.
- Enable drop: deassert `enable` at ON `dwell`=2 with `MIN_ON`=8 → `pwm`=0 and `state`=0 next edge.
- Trip (`PWM_OCP_EN`), in ON: `iest_coil`=46 (2001) → `state`=3, `fault`=1, `pwm`=0 next edge.
  - `fault_clr`=1 with `enable`=1 → stays FAULT.
  - `fault_clr`=1 with `enable`=0 → IDLE, `fault`=0.
  - 2000 (code 47) does not trip.
